// File: rtl/encrypt_pipe_xor_rotate.sv
// encrypt_pipe_xor_rotate
// Final stage of the encrypt/decrypt byte pipeline. Each valid byte is XORed
// with one of three message keys chosen round-robin. The selection advances
// every rf valid bytes (rf = 0 disables advancing). Each time the selection
// wraps from K3 back to K1, all three keys rotate left by one bit. The output
// is registered with one cycle of latency and there is no backpressure.
//
// Optional build macro ENCRYPT_XOR_CHAIN_EN: adds byte chaining. Every output
// byte is additionally XORed with a chain register. In encrypt mode (mode=1)
// the chain register takes the produced byte; in decrypt mode (mode=0) it takes
// the incoming byte. This keeps the stage self-inverse. When the macro is
// undefined, mode is ignored.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   start     in   message start pulse: loads keys and rot_freq, clears state
//   en        in   byte valid from upstream
//   din       in   scrambled byte from upstream
//   mode      in   1 = encrypt, 0 = decrypt (chaining only)
//   k1..k3    in   message keys, sampled on start
//   rot_freq  in   bytes per key before advancing, sampled on start
//   en_out    out  registered byte valid
//   data_out  out  registered output byte (held while en_out = 0)
//   key_idx   out  current key selection, 0 = K1, 1 = K2, 2 = K3
//   wrap_cnt  out  K3->K1 wraps since start, saturating at 255
module encrypt_pipe_xor_rotate #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic              mode,
    input  logic [DATA_W-1:0] k1,
    input  logic [DATA_W-1:0] k2,
    input  logic [DATA_W-1:0] k3,
    input  logic [CNT_W-1:0]  rot_freq,
    output logic              en_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        key_idx,
    output logic [7:0]        wrap_cnt
);

    typedef enum logic [1:0] {
        KEY1 = 2'd0,
        KEY2 = 2'd1,
        KEY3 = 2'd2
    } key_state_t;

    key_state_t        state, state_next, state_eff;
    logic [DATA_W-1:0] kr1, kr2, kr3;
    logic [DATA_W-1:0] kr1_next, kr2_next, kr3_next;
    logic [DATA_W-1:0] kr1_eff, kr2_eff, kr3_eff;
    logic [CNT_W-1:0]  rf, rf_eff;
    logic [CNT_W-1:0]  bc, bc_next, bc_eff;
    logic [7:0]        wrap_next, wrap_eff;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] cur_key;
    logic              advance;

`ifdef ENCRYPT_XOR_CHAIN_EN
    logic [DATA_W-1:0] chain, chain_next, chain_eff;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    function automatic logic [DATA_W-1:0] rol1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign key_idx = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= KEY1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // A start pulse is applied before the byte arriving in the same
        // cycle, so everything below works on these "effective" values.
        kr1_eff   = start ? k1 : kr1;
        kr2_eff   = start ? k2 : kr2;
        kr3_eff   = start ? k3 : kr3;
        rf_eff    = start ? rot_freq : rf;
        bc_eff    = start ? '0 : bc;
        wrap_eff  = start ? 8'd0 : wrap_cnt;
        state_eff = start ? KEY1 : state;
`ifdef ENCRYPT_XOR_CHAIN_EN
        chain_eff  = start ? '0 : chain;
        chain_next = chain_eff;
`endif

        kr1_next   = kr1_eff;
        kr2_next   = kr2_eff;
        kr3_next   = kr3_eff;
        bc_next    = bc_eff;
        wrap_next  = wrap_eff;
        state_next = state_eff;
        data_next  = data_out;
        advance    = 1'b0;

        case (state_eff)
            KEY2:    cur_key = kr2_eff;
            KEY3:    cur_key = kr3_eff;
            default: cur_key = kr1_eff;
        endcase

        if (en) begin
`ifdef ENCRYPT_XOR_CHAIN_EN
            data_next  = din ^ cur_key ^ chain_eff;
            chain_next = mode ? (din ^ cur_key ^ chain_eff) : din;
`else
            data_next = din ^ cur_key;
`endif
            if (rf_eff != '0) begin
                if (bc_eff == rf_eff - CNT_W'(1)) begin
                    bc_next = '0;
                    advance = 1'b1;
                end else begin
                    bc_next = bc_eff + CNT_W'(1);
                end
            end

            case (state_eff)
                KEY1: if (advance) state_next = KEY2;
                KEY2: if (advance) state_next = KEY3;
                KEY3: begin
                    if (advance) begin
                        // Rotated keys apply from the next valid byte on.
                        state_next = KEY1;
                        kr1_next   = rol1(kr1_eff);
                        kr2_next   = rol1(kr2_eff);
                        kr3_next   = rol1(kr3_eff);
                        wrap_next  = sat_inc(wrap_eff);
                    end
                end
                default: state_next = KEY1;
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out   <= 1'b0;
            data_out <= '0;
            kr1      <= '0;
            kr2      <= '0;
            kr3      <= '0;
            rf       <= '0;
            bc       <= '0;
            wrap_cnt <= 8'd0;
`ifdef ENCRYPT_XOR_CHAIN_EN
            chain    <= '0;
`endif
        end else begin
            en_out   <= en;
            data_out <= data_next;
            kr1      <= kr1_next;
            kr2      <= kr2_next;
            kr3      <= kr3_next;
            rf       <= rf_eff;
            bc       <= bc_next;
            wrap_cnt <= wrap_next;
`ifdef ENCRYPT_XOR_CHAIN_EN
            chain    <= chain_next;
`endif
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_xor_rotate.sv
// Testbench for encrypt_pipe_xor_rotate: directed vectors; expected output
// bytes go into a queue when issued and a monitor compares them when en_out
// is seen. Chaining vectors run only when ENCRYPT_XOR_CHAIN_EN is defined.
module tb_encrypt_pipe_xor_rotate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       mode = 1'b1;
    logic [7:0] k1 = 8'h00, k2 = 8'h00, k3 = 8'h00;
    logic [2:0] rot_freq = 3'd0;
    logic       en_out;
    logic [7:0] data_out;
    logic [1:0] key_idx;
    logic [7:0] wrap_cnt;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad = 0;

    encrypt_pipe_xor_rotate #(.DATA_W(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .din(din), .mode(mode),
        .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq),
        .en_out(en_out), .data_out(data_out), .key_idx(key_idx), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected byte per output valid.
    always @(negedge clk) begin
        if (rst && en_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL data_out_unexpected: got %0h expected none", data_out);
            end else begin
                chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        @(negedge clk);
        start = 1'b0;
        en    = 1'b1;
        din   = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
    endtask

    task automatic begin_msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [2:0] rf, input logic m);
        @(negedge clk);
        start    = 1'b1;
        en       = 1'b0;
        k1       = a;
        k2       = b;
        k3       = c;
        rot_freq = rf;
        mode     = m;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset_en_out", {31'd0, en_out}, 0);
        chk("reset_data_out", {24'd0, data_out}, 0);
        chk("reset_key_idx", {30'd0, key_idx}, 0);
        chk("reset_wrap_cnt", {24'd0, wrap_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Key schedule with rotation on wrap
        begin_msg(8'h0F, 8'hF0, 8'hAA, 3'd2, 1'b1);
        send(8'h00, 8'h0F);
        send(8'h00, 8'h0F);
        send(8'h00, 8'hF0);
        send(8'h00, 8'hF0);
        send(8'h00, 8'hAA);
        send(8'h00, 8'hAA);
        idle();
        chk("wrap_after_byte6", {24'd0, wrap_cnt}, 1);
        chk("key_idx_after_wrap", {30'd0, key_idx}, 0);
        send(8'h00, 8'h1E);
        idle();

        // rot_freq = 0: never advances
        begin_msg(8'h5A, 8'h33, 8'h00, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) send(8'hFF, 8'hA5);
        idle();
        chk("rf0_key_idx", {30'd0, key_idx}, 0);
        chk("rf0_wrap_cnt", {24'd0, wrap_cnt}, 0);

        // Gap handling and start/en collision
        begin_msg(8'h01, 8'h02, 8'h04, 3'd1, 1'b1);
        send(8'h00, 8'h01);
        idle();
        idle();
        chk("gap_en_out", {31'd0, en_out}, 0);
        chk("gap_data_held", {24'd0, data_out}, 8'h01);
        send(8'h00, 8'h02);
        @(negedge clk);
        start    = 1'b1;
        en       = 1'b1;
        din      = 8'h00;
        k1       = 8'h80;
        k2       = 8'h40;
        k3       = 8'h20;
        rot_freq = 3'd1;
        exp_q.push_back(8'h80);
        idle();
        chk("collision_key_idx", {30'd0, key_idx}, 1);

        // Keys are latched only on start
        begin_msg(8'h11, 8'h00, 8'h00, 3'd0, 1'b1);
        send(8'h00, 8'h11);
        k1 = 8'h22;
        send(8'h00, 8'h11);
        send(8'h0F, 8'h1E);
        idle();

        // Asynchronous reset mid-message, then pass-through without start
        begin_msg(8'h0F, 8'hF0, 8'hAA, 3'd2, 1'b1);
        send(8'h00, 8'h0F);
        send(8'h00, 8'h0F);
        @(negedge clk);
        en  = 1'b1;
        din = 8'h77;
        @(posedge clk);
        #1;
        chk("pre_reset_key_idx", {30'd0, key_idx}, 1);
        chk("pre_reset_en_out", {31'd0, en_out}, 1);
        #1 rst = 1'b0;
        #1;
        chk("midreset_en_out", {31'd0, en_out}, 0);
        chk("midreset_data_out", {24'd0, data_out}, 0);
        chk("midreset_key_idx", {30'd0, key_idx}, 0);
        chk("midreset_wrap_cnt", {24'd0, wrap_cnt}, 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send(8'h3C, 8'h3C);
        idle();

        // wrap_cnt saturation: 256 wraps, key = 1 rotated once per wrap
        begin_msg(8'h01, 8'h01, 8'h01, 3'd1, 1'b1);
        for (int w = 0; w < 256; w++) begin
            for (int j = 0; j < 3; j++) send(8'h00, 8'(1 << (w % 8)));
        end
        idle();
        chk("wrap_saturated", {24'd0, wrap_cnt}, 255);
        chk("sat_key_idx", {30'd0, key_idx}, 0);

`ifdef ENCRYPT_XOR_CHAIN_EN
        // Chaining: encrypt then decrypt with the same key
        begin_msg(8'h01, 8'h00, 8'h00, 3'd0, 1'b1);
        send(8'h10, 8'h11);
        send(8'h20, 8'h30);
        idle();
        begin_msg(8'h01, 8'h00, 8'h00, 3'd0, 1'b0);
        send(8'h11, 8'h10);
        send(8'h30, 8'h20);
        idle();
`endif

        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encrypt_pipe_xor_rotate.md
Name: encrypt_pipe_xor_rotate

Overview:
Final stage of the encrypt/decrypt byte pipeline. It sits directly downstream of the shift/scramble stage and consumes that stage's registered en_out and data_out. Each valid byte is XORed with one of three message keys, selected round-robin. The key selection advances every rot_freq valid bytes, and all three keys rotate left by one bit each time the selection wraps from K3 back to K1. Output is registered with 1-cycle latency and no backpressure.

Parameters:
DATA_W, 8, byte width of din/data_out/keys; only 8 is supported.
CNT_W, 3, width of the rotation-period counter; must equal width of rot_freq.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  sync pulse marking start of a message; loads keys and rot_freq, clears all state
en  input  1  byte valid from upstream stage
din  input  8  scrambled byte from upstream stage
mode  input  1  1 = encrypt, 0 = decrypt (only affects the chaining feature)
k1  input  8  key 1, sampled on start
k2  input  8  key 2, sampled on start
k3  input  8  key 3, sampled on start
rot_freq  input  3  bytes per key before advancing, sampled on start; 0 = no advance
en_out  output  1  registered byte valid
data_out  output  8  registered encrypted/decrypted byte
key_idx  output  2  currently selected key: 0 = K1, 1 = K2, 2 = K3
wrap_cnt  output  8  number of K3->K1 wraps since start, saturating at 255

Behaviour:
- Reset (rst=0, async): en_out=0, data_out=0, key_idx=0, wrap_cnt=0; key registers kr1/kr2/kr3=0; latched rot_freq rf=0; byte counter bc=0; chain register=0.
- start=1: kr1..kr3<=k1..k3; rf<=rot_freq; key_idx<=0; bc<=0; wrap_cnt<=0; chain register<=0.
- start and en in the same cycle: start takes effect first. That byte uses the new k1 unmodified, and bc becomes 1 (or 0 if rf==1, with key_idx advancing).
- Datapath: on en=1, data_out <= din ^ cur_key, where cur_key is kr1/kr2/kr3 per key_idx. en_out <= en every cycle.
- en=0: data_out holds its previous value; bc, key_idx, keys and wrap_cnt hold.
- State machine KEY1 -> KEY2 -> KEY3 -> KEY1 (encoded as key_idx 0/1/2; value 3 is unreachable and recovers to 0 on next valid byte).
- Key advance: on each valid byte, if rf!=0, bc increments. When bc reaches rf-1 on a valid byte, bc<=0 and key_idx advances. The key used for that byte is the pre-advance key.
- rf==0: key_idx stays 0, bc stays 0, no key rotation, wrap_cnt stays 0.
- Wrap (KEY3 -> KEY1): kr1, kr2 and kr3 each rotate left by 1 bit in the same cycle, effective from the next valid byte. wrap_cnt increments, saturating at 255.
- Changes on k1..k3 or rot_freq between start pulses are ignored.
- Reset mid-message: all state returns to reset values. The first message after reset must be preceded by start, otherwise keys are 0 (pass-through).
- mode has no effect on the XOR key sequence; encrypt and decrypt use identical key schedules so the stage is self-inverse.

Optional Feature:
Macro ENCRYPT_XOR_CHAIN_EN.
- Defined: byte chaining is enabled.
  - Encrypt (mode=1): data_out <= din ^ cur_key ^ chain; chain <= new data_out on each valid byte.
  - Decrypt (mode=0): data_out <= din ^ cur_key ^ chain; chain <= din on each valid byte.
  - chain is cleared by reset and start.
- Not defined: no chain register exists, mode is unused, and data_out = din ^ cur_key.

Test Plan:
1. Reset: assert rst=0 mid-stream -> en_out=0, data_out=0x00, key_idx=0, wrap_cnt=0 immediately (async).
2. Key schedule: start with k1=0x0F, k2=0xF0, k3=0xAA, rot_freq=2, then 7 valid bytes din=0x00 -> data_out 0F,0F,F0,F0,AA,AA,1E (one cycle after each en); wrap_cnt=1 after byte 6.
3. rot_freq=0 with k1=0x5A, k2=0x33: 10 bytes din=0xFF -> every data_out=0xA5; key_idx=0; wrap_cnt=0.
4. Gaps and start collision: en toggled 1,0,1 with rot_freq=1 and k1=0x01, k2=0x02 -> outputs 0x01 then 0x02, data_out held during the gap. Then start with k1=0x80 in the same cycle as en with din=0x00 -> data_out=0x80, key_idx=1 afterwards.
5. Latch check: change k1 from 0x11 to 0x22 mid-message without start -> outputs still use 0x11.
6. (ENCRYPT_XOR_CHAIN_EN) Encrypt with k1=0x01, rot_freq=0, din 0x10,0x20 -> data_out 0x11,0x30. Decrypt the same keys with din 0x11,0x30 -> data_out 0x10,0x20.
